// File: rtl/hex_display_pkg.sv
// Shared types, segment table and nibble decode function for the HEX display arbiter.
package hex_display_pkg;

  localparam int unsigned VAL_W      = 16;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned NUM_DIGITS = 4;

  typedef enum logic {
    CPU_VIEW = 1'b0,
    EVT_VIEW = 1'b1
  } state_e;

  // Active-low segments, bit0=a ... bit6=g; entry N is the glyph for nibble N.
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  localparam logic [SEG_W-1:0] SEG_ZERO = 7'b1000000;

  function automatic logic [SEG_W-1:0] nibble_to_seg(input logic [NIB_W-1:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/hex_seg_decoder.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_seg_decoder
  import hex_display_pkg::*;
(
  input  logic [NIB_W-1:0] i_nibble,
  output logic [SEG_W-1:0] o_seg
);

  always_comb begin
    o_seg = nibble_to_seg(i_nibble);
  end

endmodule

// File: rtl/hex_display_arbiter.sv
// Shares the 4-digit HEX display between the CPU PIO value and timed synth events,
// with registered segment outputs.
module hex_display_arbiter
  import hex_display_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned MIN_CYCLES  = 5_000_000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [VAL_W-1:0] cpu_value,
  input  logic             cpu_force,
  input  logic             evt_valid,
  input  logic [VAL_W-1:0] evt_value,
  output logic             evt_ready,
  output logic [SEG_W-1:0] hex0,
  output logic [SEG_W-1:0] hex1,
  output logic [SEG_W-1:0] hex2,
  output logic [SEG_W-1:0] hex3,
  output logic             showing_evt
);

  state_e                          r_state;
  state_e                          w_state_nxt;
  logic [CNT_W-1:0]                r_cnt;
  logic [CNT_W-1:0]                w_cnt_nxt;
  logic [VAL_W-1:0]                r_evt;
  logic [VAL_W-1:0]                w_evt_nxt;
  logic                            w_accept;
  logic [VAL_W-1:0]                w_sel;
  logic [NUM_DIGITS-1:0][SEG_W-1:0] w_seg;
  logic [NUM_DIGITS-1:0][SEG_W-1:0] r_hex;
  logic                            r_showing;

  // A new event may replace the shown one only after its minimum display time.
  assign evt_ready = !reset && !cpu_force &&
                     ((r_state == CPU_VIEW) || (r_cnt >= CNT_W'(MIN_CYCLES)));
  assign w_accept  = evt_valid && evt_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CPU_VIEW;
      r_cnt   <= '0;
      r_evt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_evt   <= w_evt_nxt;
    end
  end

  // Next-state: force beats accept, accept beats expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_evt_nxt   = r_evt;
    if (cpu_force) begin
      w_state_nxt = CPU_VIEW;
      w_cnt_nxt   = '0;
    end else if (w_accept) begin
      w_state_nxt = EVT_VIEW;
      w_cnt_nxt   = '0;
      w_evt_nxt   = evt_value;
    end else if (r_state == EVT_VIEW) begin
      if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
        w_state_nxt = CPU_VIEW;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  assign w_sel = (r_state == EVT_VIEW) ? r_evt : cpu_value;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    hex_seg_decoder u_dec (
      .i_nibble (w_sel[NIB_W*g +: NIB_W]),
      .o_seg    (w_seg[g])
    );
  end

  // Segments and the source flag share one stage so they stay aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hex     <= {NUM_DIGITS{SEG_ZERO}};
      r_showing <= 1'b0;
    end else begin
      r_hex     <= w_seg;
      r_showing <= (r_state == EVT_VIEW);
    end
  end

  assign hex0        = r_hex[0];
  assign hex1        = r_hex[1];
  assign hex2        = r_hex[2];
  assign hex3        = r_hex[3];
  assign showing_evt = r_showing;

endmodule
